// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers feed a shift-register window; one window per interior pixel.
module conv_window_gen #(
    parameter int PIXEL_WIDTH = 16,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [PIXEL_WIDTH-1:0] s_pixel,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic signed [PIXEL_WIDTH-1:0] x00,
    output logic signed [PIXEL_WIDTH-1:0] x01,
    output logic signed [PIXEL_WIDTH-1:0] x02,
    output logic signed [PIXEL_WIDTH-1:0] x10,
    output logic signed [PIXEL_WIDTH-1:0] x11,
    output logic signed [PIXEL_WIDTH-1:0] x12,
    output logic signed [PIXEL_WIDTH-1:0] x20,
    output logic signed [PIXEL_WIDTH-1:0] x21,
    output logic signed [PIXEL_WIDTH-1:0] x22,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic signed [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] lb0_rd;
    logic signed [PIXEL_WIDTH-1:0] lb1_rd;

    logic accept;
    logic col_end;
    logic row_end;
    logic win_pos;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    assign win_pos = (row >= ROW_TWO) && (col >= COL_TWO);
    assign lb0_rd  = lb0[col];
    assign lb1_rd  = lb1[col];

    // Line buffers are never reset; a new frame rewrites them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= s_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            x00     <= '0;
            x01     <= '0;
            x02     <= '0;
            x10     <= '0;
            x11     <= '0;
            x12     <= '0;
            x20     <= '0;
            x21     <= '0;
            x22     <= '0;
        end else if (accept) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) begin
                row <= row_end ? '0 : row + 1'b1;
            end
            x00     <= x01;
            x01     <= x02;
            x02     <= lb0_rd;
            x10     <= x11;
            x11     <= x12;
            x12     <= lb1_rd;
            x20     <= x21;
            x21     <= x22;
            x22     <= s_pixel;
            m_valid <= win_pos;
            m_last  <= win_pos && col_end && row_end;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16, the signed pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 64, pixels per row (>= 3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (>= 3).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port s_pixel, input, PIXEL_WIDTH signed, raster-order input pixel.
REQ-007 SHALL have port s_valid, input, 1, s_pixel is valid.
REQ-008 SHALL have port s_ready, output, 1, block accepts s_pixel this cycle.
REQ-009 SHALL have ports x00, x01, x02, x10, x11, x12, x20, x21, x22, output, PIXEL_WIDTH signed each, the 3x3 window (xRC: R is the row and C is the column, 0 is the top/left).
REQ-010 SHALL have port m_valid, output, 1, window valid.
REQ-011 SHALL have port m_ready, input, 1, downstream (multiply-adder stage) consumes the window.
REQ-012 SHALL have port m_last, output, 1, qualifies the final window of a frame.

Function
REQ-013 SHALL accept a pixel on a cycle with s_valid && s_ready; no other cycle changes any state except reset.
REQ-014 SHALL drive s_ready = !m_valid || m_ready (combinational); each input pixel produces at most one window.
REQ-015 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) of the next pixel to be accepted; col increments per accept and wraps to 0, incrementing row; row wraps to 0 after the last pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1).
REQ-016 SHALL hold two line buffers LB0 (row-2) and LB1 (row-1), IMG_WIDTH entries each, addressed by col, read asynchronously; on accept: LB0[col] <= LB1[col], LB1[col] <= s_pixel.
REQ-017 SHALL, on accept, shift the window left one column (xR0<=xR1, xR1<=xR2) and load x02<=LB0[col], x12<=LB1[col], x22<=s_pixel (pre-write read values).
REQ-018 SHALL, on accept with row>=2 and col>=2, set m_valid=1 on the next cycle; the window is then the pixels at rows row-2..row and columns col-2..col ("valid" convolution, no padding).
REQ-019 SHALL, on accept at other positions, set m_valid=0 on the next cycle (if the previous window was pending, it is consumed in the same cycle, per REQ-014).
REQ-020 SHALL clear m_valid when m_valid && m_ready and no accept occurs.
REQ-021 SHALL hold x00..x22, m_valid and m_last stable while m_valid && !m_ready.
REQ-022 SHALL register m_last=1 with the window produced by the accept at row=IMG_HEIGHT-1, col=IMG_WIDTH-1; otherwise m_last=0.
REQ-023 SHALL produce exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame; latency from the accept to m_valid is 1 cycle.
REQ-024 SHALL start the next frame immediately after wrap with no idle cycle; the first two rows of the new frame overwrite the line buffers before any window is produced.
REQ-025 SHALL perform no arithmetic on pixel values; the data path is pass-through only.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, set col=0, row=0, m_valid=0, m_last=0, and x00..x22=0; s_ready is then 1.
REQ-027 SHALL leave the line buffer contents unreset; no window depends on them before they are rewritten.
REQ-028 SHALL discard any partial frame on reset mid-operation; the next accepted pixel is (row 0, col 0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4*row+col, m_ready=1 unless stated)
REQ-029 SHALL pass: stream pixels 0..15 back-to-back -> exactly 4 windows; the first window follows the accept of pixel 10 and has x00..x22 = 0,1,2,4,5,6,8,9,10; the last window has 5,6,7,9,10,11,13,14,15 with m_last=1.
REQ-030 SHALL pass: same stream with m_ready=0 for 3 cycles when the first window appears -> window 0,1,2,4,5,6,8,9,10 held stable, s_ready=0, no pixel lost; the remaining windows are correct.
REQ-031 SHALL pass: s_valid toggled 1/0 every cycle -> the same 4 windows, each 1 cycle after its accept, and m_valid is low between windows.
REQ-032 SHALL pass: two frames back-to-back -> 8 windows; the second frame's first window again equals 0,1,2,4,5,6,8,9,10, and m_last is asserted twice.
REQ-033 SHALL pass: rst_n=0 for 1 cycle after pixel 9, then a full frame 0..15 -> m_valid=0 and outputs 0 after reset; output then matches REQ-029 exactly.
